remote_send: RTL and testbench

NEC-format infrared transmitter. It is the sending end of the protocol that `remote_rcv` decodes. It takes an 8-bit address and an 8-bit command, or a repeat request, and drives the IR LED pin with a 38 kHz modulated NEC frame. It runs in the `sys_clk` (50 MHz) domain and is used for board-to-board control and for loopback testing of `remote_rcv`.

---
 rtl/remote_send.sv | 163 ++++++++++++++++
 tb/tb_remote_send.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/remote_send.sv
// remote_send: NEC-format infrared transmitter.
// Sends either a full frame (16T lead mark, 8T lead space, 32 data bits
// LSB first as {~data, data, ~addr, addr}, 1T stop mark) or a repeat code
// (16T lead mark, 4T lead space, 1T stop mark), then holds the line low for
// GUARD_UNITS units before accepting the next request.
// Ports:
//   sys_clk, sys_rst_n      clock, asynchronous active-low reset
//   tx_start, tx_repeat     request strobe (sampled in idle), repeat qualifier
//   tx_addr, tx_data        address/command bytes, latched on acceptance
//   remote_out              registered LED drive, active-high
//   tx_busy, tx_done        busy window and one-cycle completion pulse
module remote_send #(
  parameter int UNIT_CYC    = 28125,
  parameter int CARRIER_DIV = 1316,
  parameter int CARRIER_EN  = 1,
  parameter int GUARD_UNITS = 72
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       tx_start,
  input  logic       tx_repeat,
  input  logic [7:0] tx_addr,
  input  logic [7:0] tx_data,
  output logic       remote_out,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int UW   = $clog2(UNIT_CYC + 1);
  localparam int CW   = $clog2(CARRIER_DIV + 1);
  localparam int MAXU = (GUARD_UNITS > 16) ? GUARD_UNITS : 16;
  localparam int SW   = $clog2(MAXU + 1);

  localparam logic [UW-1:0] UNIT_LAST = UW'(UNIT_CYC - 1);
  localparam logic [CW-1:0] CAR_LAST  = CW'(CARRIER_DIV - 1);
  localparam logic [CW-1:0] CAR_HALF  = CW'(CARRIER_DIV / 2);
  localparam logic          CAR_OFF   = (CARRIER_EN == 0);

  typedef enum logic [2:0] {
    S_IDLE, S_LEAD_MARK, S_LEAD_SPACE, S_BIT_MARK, S_BIT_SPACE, S_STOP_MARK, S_GUARD
  } state_t;

  state_t        state_q,    state_d;
  logic [UW-1:0] unit_cnt_q, unit_cnt_d;
  logic [SW-1:0] unit_num_q, unit_num_d;
  logic [4:0]    bit_idx_q,  bit_idx_d;
  logic [CW-1:0] car_cnt_q,  car_cnt_d;
  logic [31:0]   shift_q,    shift_d;
  logic          rep_q,      rep_d;
  logic          out_q,      out_d;
  logic          busy_q,     busy_d;
  logic          done_q,     done_d;

  logic          unit_tick;
  logic          seg_end;
  logic          mark_d;
  logic [SW-1:0] state_len;

  always_comb begin
    state_d    = state_q;
    unit_cnt_d = unit_cnt_q;
    unit_num_d = unit_num_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    rep_d      = rep_q;
    done_d     = 1'b0;

    unit_tick = (unit_cnt_q == UNIT_LAST);

    // Length of the current state in units; a data bit's space length is
    // chosen by the bit currently at the bottom of the shift register.
    case (state_q)
      S_LEAD_MARK:  state_len = SW'(16);
      S_LEAD_SPACE: state_len = rep_q ? SW'(4) : SW'(8);
      S_BIT_SPACE:  state_len = shift_q[0] ? SW'(3) : SW'(1);
      S_GUARD:      state_len = SW'(GUARD_UNITS);
      default:      state_len = SW'(1);
    endcase

    seg_end = unit_tick && (unit_num_q == state_len - SW'(1));

    if (state_q == S_IDLE) begin
      unit_cnt_d = '0;
      unit_num_d = '0;
      if (tx_start) begin
        state_d   = S_LEAD_MARK;
        shift_d   = {~tx_data, tx_data, ~tx_addr, tx_addr};
        rep_d     = tx_repeat;
        bit_idx_d = '0;
      end
    end else begin
      unit_cnt_d = unit_tick ? '0 : unit_cnt_q + UW'(1);
      if (seg_end) begin
        unit_num_d = '0;
        case (state_q)
          S_LEAD_MARK:  state_d = S_LEAD_SPACE;
          S_LEAD_SPACE: state_d = rep_q ? S_STOP_MARK : S_BIT_MARK;
          S_BIT_MARK:   state_d = S_BIT_SPACE;
          S_BIT_SPACE: begin
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + 5'd1;
            state_d   = (bit_idx_q == 5'd31) ? S_STOP_MARK : S_BIT_MARK;
          end
          S_STOP_MARK:  state_d = S_GUARD;
          S_GUARD: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
          default:      state_d = S_IDLE;
        endcase
      end else if (unit_tick) begin
        unit_num_d = unit_num_q + SW'(1);
      end
    end

    // Carrier phase restarts at the first cycle of every mark so each mark
    // begins with a full high half-period.
    mark_d = (state_d == S_LEAD_MARK) || (state_d == S_BIT_MARK) ||
             (state_d == S_STOP_MARK);
    if (!mark_d || (state_d != state_q))
      car_cnt_d = '0;
    else
      car_cnt_d = (car_cnt_q == CAR_LAST) ? '0 : car_cnt_q + CW'(1);

    // Outputs are computed from next-state values so the registered pins
    // line up with the state they describe.
    out_d  = mark_d && ((car_cnt_d < CAR_HALF) || CAR_OFF);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= S_IDLE;
      unit_cnt_q <= '0;
      unit_num_q <= '0;
      bit_idx_q  <= '0;
      car_cnt_q  <= '0;
      out_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      unit_cnt_q <= unit_cnt_d;
      unit_num_q <= unit_num_d;
      bit_idx_q  <= bit_idx_d;
      car_cnt_q  <= car_cnt_d;
      out_q      <= out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Frame payload is only meaningful once loaded on acceptance.
  always_ff @(posedge sys_clk) begin
    shift_q <= shift_d;
    rep_q   <= rep_d;
  end

  assign remote_out = out_q;
  assign tx_busy    = busy_q;
  assign tx_done    = done_q;

endmodule

// File: tb/tb_remote_send.sv
// Bench for remote_send. Two instances: dut0 (UNIT_CYC=8, envelope only,
// GUARD_UNITS=4) and dut1 (UNIT_CYC=40, CARRIER_DIV=10, carrier on).
// Expected per-cycle {remote_out, tx_busy, tx_done} values are queued when a
// request is accepted and compared every negedge; with an empty queue the
// outputs must be idle.
module tb_remote_send;

  logic       clk;
  logic       rst_n;
  logic       start0, rep0, start1, rep1;
  logic [7:0] addr0, data0, addr1, data1;
  logic       out0, busy0, done0, out1, busy1, done1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [2:0] q0[$];
  logic [2:0] q1[$];

  remote_send #(.UNIT_CYC(8), .CARRIER_DIV(10), .CARRIER_EN(0), .GUARD_UNITS(4)) dut0 (
    .sys_clk(clk), .sys_rst_n(rst_n), .tx_start(start0), .tx_repeat(rep0),
    .tx_addr(addr0), .tx_data(data0), .remote_out(out0), .tx_busy(busy0), .tx_done(done0)
  );

  remote_send #(.UNIT_CYC(40), .CARRIER_DIV(10), .CARRIER_EN(1), .GUARD_UNITS(4)) dut1 (
    .sys_clk(clk), .sys_rst_n(rst_n), .tx_start(start1), .tx_repeat(rep1),
    .tx_addr(addr1), .tx_data(data1), .remote_out(out1), .tx_busy(busy1), .tx_done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Marks on dut1 carry a 10-cycle carrier, 5 high then 5 low.
  task automatic add_seg(input int inst, input bit mark, input int len);
    logic [2:0] e;
    bit o;
    for (int k = 0; k < len; k++) begin
      o = mark && ((inst == 0) || ((k % 10) < 5));
      e = {o, 1'b1, 1'b0};
      if (inst == 0) q0.push_back(e);
      else           q1.push_back(e);
    end
  endtask

  task automatic push_frame(input int inst, input logic [7:0] a, input logic [7:0] d,
                            input logic r);
    int u;
    logic [31:0] w;
    u = (inst == 0) ? 8 : 40;
    w = {~d, d, ~a, a};
    add_seg(inst, 1'b1, 16 * u);
    add_seg(inst, 1'b0, (r ? 4 : 8) * u);
    if (!r) begin
      for (int i = 0; i < 32; i++) begin
        add_seg(inst, 1'b1, u);
        add_seg(inst, 1'b0, (w[i] ? 3 : 1) * u);
      end
    end
    add_seg(inst, 1'b1, u);
    add_seg(inst, 1'b0, 4 * u);
    if (inst == 0) q0.push_back(3'b001);
    else           q1.push_back(3'b001);
  endtask

  // Called at a negedge with the DUT idle; returns 1 time unit after the
  // accepting edge with the inputs scrambled.
  task automatic send(input int inst, input logic [7:0] a, input logic [7:0] d,
                      input logic r);
    if (inst == 0) begin addr0 = a; data0 = d; rep0 = r; start0 = 1'b1; end
    else           begin addr1 = a; data1 = d; rep1 = r; start1 = 1'b1; end
    @(posedge clk);
    push_frame(inst, a, d, r);
    #1;
    if (inst == 0) begin
      start0 = 1'b0; addr0 = 8'($urandom); data0 = 8'($urandom); rep0 = 1'($urandom);
    end else begin
      start1 = 1'b0; addr1 = 8'($urandom); data1 = 8'($urandom); rep1 = 1'($urandom);
    end
  endtask

  task automatic wait_done(input int inst);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      if (((inst == 0) ? done0 : done1) === 1'b1) got = 1'b1;
    end
    if (!got) chk("done_timeout", 32'd0, 32'd1);
  endtask

  always @(negedge clk) begin
    logic [2:0] e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk("dut0_sample", {29'd0, out0, busy0, done0}, {29'd0, e});
    end else begin
      chk("dut0_idle", {29'd0, out0, busy0, done0}, 32'd0);
    end
  end

  always @(negedge clk) begin
    logic [2:0] e;
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("dut1_sample", {29'd0, out1, busy1, done1}, {29'd0, e});
    end else begin
      chk("dut1_idle", {29'd0, out1, busy1, done1}, 32'd0);
    end
  end

  initial begin
    start0 = 1'b0; rep0 = 1'b0; addr0 = '0; data0 = '0;
    start1 = 1'b0; rep1 = 1'b0; addr1 = '0; data1 = '0;
    rst_n  = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_state0", {29'd0, out0, busy0, done0}, 32'd0);
    chk("reset_state1", {29'd0, out1, busy1, done1}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Full frame, then a back-to-back repeat code in the tx_done cycle.
    send(0, 8'h00, 8'h45, 1'b0);
    chk("start_latency", {30'd0, out0, busy0}, 32'd3);
    wait_done(0);
    send(0, 8'hA5, 8'h3C, 1'b1);
    wait_done(0);

    // Start while busy is ignored and nothing follows the frame.
    @(negedge clk);
    send(0, 8'h12, 8'h34, 1'b0);
    repeat (300) @(negedge clk);
    start0 = 1'b1; data0 = 8'hFF; addr0 = 8'h77; rep0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_done(0);
    repeat (1100) @(negedge clk);

    // Reset during bit 10 drops outputs at once; a fresh frame follows.
    send(0, 8'h00, 8'h55, 1'b0);
    repeat (389) @(posedge clk);
    #3 rst_n = 1'b0;
    q0.delete();
    q1.delete();
    #1;
    chk("rst_mid_out",  {31'd0, out0},  32'd0);
    chk("rst_mid_busy", {31'd0, busy0}, 32'd0);
    chk("rst_mid_done", {31'd0, done0}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    send(0, 8'h00, 8'h18, 1'b0);
    wait_done(0);

    // Carrier shape on a repeat code.
    @(negedge clk);
    send(1, 8'h00, 8'h00, 1'b1);
    wait_done(1);
    repeat (20) @(negedge clk);

    chk("queue0_drained", q0.size(), 32'd0);
    chk("queue1_drained", q1.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
